multi_seg_boot_loader: RTL

//  Boot-time copier: reads a segment table from flash, copies up to MAX_SEG segments
//  (dest SRAM addr + word count each) flash->SRAM, optionally verifies an XOR checksum.

---
 rtl/multi_seg_boot_loader.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_seg_boot_loader.sv
// rtl/multi_seg_boot_loader.sv - table-driven multi-segment flash-to-SRAM boot copier
// Reads a segment table from flash, copies each segment to SRAM and verifies an XOR checksum.
module multi_seg_boot_loader #(
  parameter int DW        = 32,
  parameter int FAW       = 25,
  parameter int SAW       = 22,
  parameter int MAX_SEG   = 4,
  parameter int HDR_BASE  = 0,
  parameter int FLASH_LAT = 1,
  parameter int CHECK_EN  = 1,
  localparam int SIW      = $clog2(MAX_SEG + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           flash_ready,
  input  logic [DW-1:0]  flash_data,
  output logic [FAW-1:0] flash_addr,
  output logic           flash_cs,
  input  logic           sram_ready,
  output logic [DW-1:0]  sram_data,
  output logic [SAW-1:0] sram_addr,
  output logic           sram_cs,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [1:0]     err_code,
  output logic [SIW-1:0] seg_idx
);

  localparam int LW = $clog2(FLASH_LAT + 1);
  localparam int CW = ((DW > SAW) ? DW : SAW) + 1;
  localparam logic [CW-1:0] SEG_LIM = CW'(1) << SAW;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_N, S_RD_DEST, S_RD_SIZE, S_SEG_CHK,
    S_COPY_RD, S_COPY_WR, S_RD_CHK, S_FLUSH, S_DONE, S_ERR
  } state_t;

  // Per-access sub-phase: reads use A=strobe, B=latency, C=wait ready;
  // writes use A=wait ready, B=strobe, C=settle.
  typedef enum logic [1:0] {PH_A, PH_B, PH_C} phase_t;

  state_t         state_q, state_d;
  phase_t         ph_q, ph_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic [SIW-1:0] n_q, n_d, k_q, k_d;
  logic [SAW-1:0] dest_q, dest_d;
  logic [DW-1:0]  size_q, size_d, widx_q, widx_d;
  logic [FAW-1:0] ptr_q, ptr_d;
  logic [DW-1:0]  csum_q, csum_d, data_q, data_d;
  logic           flash_cs_q, flash_cs_d, sram_cs_q, sram_cs_d;
  logic [FAW-1:0] flash_addr_q, flash_addr_d;
  logic [SAW-1:0] sram_addr_q, sram_addr_d;
  logic [DW-1:0]  sram_data_q, sram_data_d;
  logic           busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]     err_code_q, err_code_d;

  logic           rd_state, rd_fire, seg_adv, seg_last, err_set;
  logic [1:0]     err_val;
  logic [FAW-1:0] tbl_addr, rd_addr;
  logic [CW-1:0]  seg_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ph_q         <= PH_A;
      lat_q        <= '0;
      n_q          <= '0;
      k_q          <= '0;
      dest_q       <= '0;
      size_q       <= '0;
      widx_q       <= '0;
      ptr_q        <= '0;
      csum_q       <= '0;
      data_q       <= '0;
      flash_cs_q   <= 1'b0;
      flash_addr_q <= '0;
      sram_cs_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      lat_q        <= lat_d;
      n_q          <= n_d;
      k_q          <= k_d;
      dest_q       <= dest_d;
      size_q       <= size_d;
      widx_q       <= widx_d;
      ptr_q        <= ptr_d;
      csum_q       <= csum_d;
      data_q       <= data_d;
      flash_cs_q   <= flash_cs_d;
      flash_addr_q <= flash_addr_d;
      sram_cs_q    <= sram_cs_d;
      sram_addr_q  <= sram_addr_d;
      sram_data_q  <= sram_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    lat_d        = lat_q;
    n_d          = n_q;
    k_d          = k_q;
    dest_d       = dest_q;
    size_d       = size_q;
    widx_d       = widx_q;
    ptr_d        = ptr_q;
    csum_d       = csum_q;
    data_d       = data_q;
    flash_cs_d   = 1'b0;
    flash_addr_d = flash_addr_q;
    sram_cs_d    = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_data_d  = sram_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    rd_fire      = 1'b0;
    seg_adv      = 1'b0;
    err_set      = 1'b0;
    err_val      = 2'd0;

    tbl_addr = FAW'(HDR_BASE + 1) + (FAW'(k_q) << 1);
    seg_last = (k_q == n_q - SIW'(1));
    seg_end  = CW'(dest_q) + CW'(size_q);

    case (state_q)
      S_RD_N:    rd_addr = FAW'(HDR_BASE);
      S_RD_DEST: rd_addr = tbl_addr;
      S_RD_SIZE: rd_addr = tbl_addr + FAW'(1);
      default:   rd_addr = ptr_q;
    endcase

    rd_state = (state_q == S_RD_N) || (state_q == S_RD_DEST) || (state_q == S_RD_SIZE) ||
               (state_q == S_COPY_RD) || (state_q == S_RD_CHK);

    // Shared flash read handshake; rd_fire marks the cycle flash_data is taken.
    if (rd_state) begin
      case (ph_q)
        PH_A: begin
          flash_cs_d   = 1'b1;
          flash_addr_d = rd_addr;
          lat_d        = '0;
          ph_d         = PH_B;
        end
        PH_B: begin
          if (lat_q == LW'(FLASH_LAT)) ph_d = PH_C;
          else                         lat_d = lat_q + LW'(1);
        end
        default: begin
          if (flash_ready) begin
            rd_fire = 1'b1;
            ph_d    = PH_A;
          end
        end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start && flash_ready) begin
          state_d = S_RD_N;
          ph_d    = PH_A;
          busy_d  = 1'b1;
          n_d     = '0;
          k_d     = '0;
          csum_d  = '0;
        end
      end
      S_RD_N: begin
        if (rd_fire) begin
          if (flash_data == '0 || flash_data > DW'(MAX_SEG)) begin
            err_set = 1'b1;
            err_val = 2'd1;
          end else begin
            n_d     = flash_data[SIW-1:0];
            ptr_d   = FAW'(HDR_BASE + 1) + (FAW'(flash_data[SIW-1:0]) << 1);
            state_d = S_RD_DEST;
          end
        end
      end
      S_RD_DEST: begin
        if (rd_fire) begin
          dest_d  = flash_data[SAW-1:0];
          state_d = S_RD_SIZE;
        end
      end
      S_RD_SIZE: begin
        if (rd_fire) begin
          size_d  = flash_data;
          state_d = S_SEG_CHK;
        end
      end
      S_SEG_CHK: begin
        // Wide compare so a huge size cannot alias back into range.
        if (seg_end > SEG_LIM) begin
          err_set = 1'b1;
          err_val = 2'd2;
        end else if (size_q == '0) begin
          seg_adv = 1'b1;
        end else begin
          widx_d  = '0;
          state_d = S_COPY_RD;
        end
      end
      S_COPY_RD: begin
        if (rd_fire) begin
          data_d  = flash_data;
          csum_d  = csum_q ^ flash_data;
          ptr_d   = ptr_q + FAW'(1);
          state_d = S_COPY_WR;
        end
      end
      S_COPY_WR: begin
        case (ph_q)
          PH_A: begin
            if (sram_ready) begin
              sram_cs_d   = 1'b1;
              sram_addr_d = dest_q + widx_q[SAW-1:0];
              sram_data_d = data_q;
              ph_d        = PH_B;
            end
          end
          PH_B: ph_d = PH_C;
          default: begin
            ph_d = PH_A;
            if (widx_q + DW'(1) == size_q) begin
              seg_adv = 1'b1;
            end else begin
              widx_d  = widx_q + DW'(1);
              state_d = S_COPY_RD;
            end
          end
        endcase
      end
      S_RD_CHK: begin
        if (rd_fire) begin
          if (flash_data != csum_q) begin
            err_set = 1'b1;
            err_val = 2'd3;
          end else begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (sram_ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        // DONE/ERR: a held start must not retrigger another load.
        if (!start) begin
          state_d    = S_IDLE;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = 2'd0;
          k_d        = '0;
        end
      end
    endcase

    if (seg_adv) begin
      if (seg_last) begin
        state_d = (CHECK_EN != 0) ? S_RD_CHK : S_FLUSH;
      end else begin
        k_d     = k_q + SIW'(1);
        state_d = S_RD_DEST;
      end
    end

    if (err_set) begin
      state_d    = S_ERR;
      error_d    = 1'b1;
      busy_d     = 1'b0;
      err_code_d = err_val;
    end
  end

  assign flash_cs   = flash_cs_q;
  assign flash_addr = flash_addr_q;
  assign sram_cs    = sram_cs_q;
  assign sram_addr  = sram_addr_q;
  assign sram_data  = sram_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign seg_idx    = k_q;

endmodule
